// File: rtl/sram_add_ctrl.sv
// List-sum controller: walks a length-prefixed word list in SRAM from word N down to word 1.
// Optional carry detection on the accumulator is built when SRAM_ADD_CTRL_OVF_EN is defined.
module sram_add_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf,
  input  logic        ld_we,
  input  logic [8:0]  ld_addr,
  input  logic [31:0] ld_din,
  output logic        first,
  output logic        sel,
  output logic        addr_minus_en,
  output logic        sram_we,
  output logic [8:0]  waddr,
  output logic [31:0] din,
  input  logic [31:0] dout,
  input  logic        zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, ACC = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;

`ifdef SRAM_ADD_CTRL_OVF_EN
  logic        ovf_q, ovf_d;
  logic [32:0] sum;
  assign sum = {1'b0, result_q} + {1'b0, dout};
`else
  logic [31:0] sum;
  assign sum = result_q + dout;
`endif

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
`ifdef SRAM_ADD_CTRL_OVF_EN
    ovf_d         = ovf_q;
`endif
    busy          = (state_q != IDLE);
    done          = 1'b0;
    first         = 1'b0;
    sel           = 1'b0;
    addr_minus_en = 1'b0;
    sram_we       = 1'b0;
    waddr         = '0;
    din           = '0;
    case (state_q)
      IDLE: begin
        // A host write wins over start; the host has to reissue start.
        sram_we = ld_we & ~rst;
        waddr   = ld_addr;
        din     = ld_din;
        if (start && !ld_we && !abort) begin
          state_d  = HEAD;
          result_d = '0;
`ifdef SRAM_ADD_CTRL_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      HEAD: begin
        first   = 1'b1;
        sel     = 1'b1;
        state_d = ACC;
      end
      ACC: begin
        if (!zero) begin
          addr_minus_en = 1'b1;
          result_d      = sum[31:0];
`ifdef SRAM_ADD_CTRL_OVF_EN
          ovf_d         = ovf_q | sum[32];
`endif
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
`ifdef SRAM_ADD_CTRL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifdef SRAM_ADD_CTRL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign result = result_q;
`ifdef SRAM_ADD_CTRL_OVF_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sram_add_ctrl.sv
// Bench for sram_add_ctrl: SRAM + address-register datapath model, list-sum reference model.
module tb_sram_add_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, ld_we;
  logic [8:0]  ld_addr;
  logic [31:0] ld_din;
  logic        busy, done, ovf, first, sel, addr_minus_en, sram_we, zero;
  logic [31:0] result, din, dout;
  logic [8:0]  waddr, raddr;

  logic [31:0] mem [512] = '{default: '0};
  logic [31:0] ref_mem [512];
  logic [8:0]  areg = '0;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  sram_add_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_din(ld_din),
    .first(first), .sel(sel), .addr_minus_en(addr_minus_en),
    .sram_we(sram_we), .waddr(waddr), .din(din),
    .dout(dout), .zero(zero)
  );

  // Datapath: SRAM with combinational read, address register with load/decrement.
  assign raddr = first ? 9'd0 : areg;
  assign dout  = mem[raddr];
  assign zero  = (areg == 9'd0);

  always @(posedge clk) begin
    if (sram_we) mem[waddr] <= din;
    if (sel) areg <= dout[8:0];
    else if (addr_minus_en) areg <= areg - 9'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_din = d;
    #1;
    chk("ld_we_fwd", {31'd0, sram_we}, 32'd1);
    chk("ld_din_fwd", din, d);
    @(posedge clk);
    #1 ld_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // mode: 0 normal, 1 host write during ACC, 2 abort at T+3, 3 reset at T+3
  task automatic run(input int mode);
    int          n, cnt, dec;
    logic [63:0] s;
    logic [31:0] acc;
    logic [31:0] eovf;
    logic [31:0] keep5;
    n = int'(ref_mem[0][8:0]);
    acc = '0; eovf = '0;
    for (int i = n; i >= 1; i--) begin
      s = {32'd0, acc} + {32'd0, ref_mem[i]};
      if (s[32]) eovf = 32'd1;
      acc = s[31:0];
    end
`ifndef SRAM_ADD_CTRL_OVF_EN
    eovf = '0;
`endif
    keep5 = ref_mem[5];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1; dec = 0;
    chk("busy_head", {31'd0, busy}, 32'd1);
    chk("result_clr", result, 32'd0);
    chk("ovf_clr", {31'd0, ovf}, 32'd0);
    while (!done && cnt < 600) begin
      if (cnt == 3 && mode == 1) begin
        ld_we = 1'b1; ld_addr = 9'd5; ld_din = ~keep5;
        #1 chk("ld_lockout", {31'd0, sram_we}, 32'd0);
      end
      if (cnt == 3 && mode == 2) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("abort_nodone", {30'd0, done, busy}, 32'd0);
        end
        return;
      end
      if (cnt == 3 && mode == 3) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_run_ctl", {25'd0, busy, done, ovf, first, sel, addr_minus_en, sram_we}, 32'd0);
        chk("rst_run_res", result, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("rst_nodone", {30'd0, done, busy}, 32'd0);
        end
        return;
      end
      if (addr_minus_en) dec++;
      if (!busy) chk("busy_run", {31'd0, busy}, 32'd1);
      @(negedge clk);
      cnt++;
    end
    ld_we = 1'b0;
    chk("latency", cnt, n + 3);
    chk("done_busy", {31'd0, busy}, 32'd1);
    chk("decrements", dec, n);
    chk("result", result, acc);
    chk("ovf", {31'd0, ovf}, eovf);
    if (mode == 1) chk("mem5_kept", mem[5], keep5);
    @(negedge clk);
    chk("done_pulse", {30'd0, done, busy}, 32'd0);
    chk("result_hold", result, acc);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_din = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {25'd0, busy, done, ovf, first, sel, addr_minus_en, sram_we}, 32'd0);
    chk("rst_res", result, 32'd0);
    rst = 1'b0;

    // Basic sum
    load(0, 3); load(1, 10); load(2, 20); load(3, 30);
    run(0);
    // Empty list
    load(0, 32'hABCD_EE00);
    run(0);
    // Carry out of bit 31, then back-to-back run that must not see stale ovf
    load(0, 2); load(1, 32'hFFFF_FFFF); load(2, 32'h0000_0002);
    run(0);
    load(0, 1); load(1, 32'h0000_0007);
    run(0);
    run(0);

    // Host write together with start in IDLE: write wins, block stays idle
    @(negedge clk);
    start = 1'b1; ld_we = 1'b1; ld_addr = 9'd7; ld_din = 32'h1234_5678;
    #1 chk("ldstart_we", {31'd0, sram_we}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0; ld_we = 1'b0;
    ref_mem[7] = 32'h1234_5678;
    chk("ldstart_idle", {31'd0, busy}, 32'd0);
    chk("ldstart_mem", mem[7], 32'h1234_5678);

    // N=5 list for lockout, abort and reset-mid-run
    load(0, 5);
    for (int i = 1; i <= 5; i++) load(9'(i), 32'(i * 100 + 1));
    run(1);
    run(2);
    run(3);
    run(0);

    // Randomized lists
    for (int t = 0; t < 12; t++) begin
      int n;
      n = (t == 11) ? 511 : int'($urandom_range(0, 14));
      load(0, {$urandom() & 32'hFFFF_FE00} | 32'(n));
      for (int i = 1; i <= n; i++)
        load(9'(i), ($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(0, 1000));
      run(0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sram_add_ctrl.md
SRAM_ADD_CTRL -- requirements
Module: sram_add_ctrl

Interface
REQ-001 SHALL use a single clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.

REQ-002 SHALL provide these host-side ports:
- start  in  1  pulse that requests one list-sum traversal.
- abort  in  1  returns the block to IDLE immediately; no done pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a traversal completes.
- result  out  32  sum of the traversal; held until the next start is accepted.
- ovf  out  1  sticky carry-out of the accumulation (see REQ-017).

REQ-003 SHALL provide these host load ports:
- ld_we  in  1  host write request.
- ld_addr  in  9  host write address.
- ld_din  in  32  host write data.

REQ-004 SHALL provide these ports toward the SRAM datapath:
- first  out  1  forces the read address to 0.
- sel  out  1  loads the datapath address register from the read data.
- addr_minus_en  out  1  decrements the datapath address register.
- sram_we  out  1  SRAM write enable.
- waddr  out  9  SRAM write address.
- din  out  32  SRAM write data.
- dout  in  32  SRAM read data; valid in the same cycle the address is driven.
- zero  in  1  high when the datapath address register equals 0.

Function
REQ-005 SHALL implement four states, encoded as IDLE=0, HEAD=1, ACC=2, DONE=3.

REQ-006 In IDLE, SHALL drive first=0, sel=0, addr_minus_en=0, so the datapath address register holds its value.

REQ-007 In IDLE, SHALL forward the load port: sram_we=ld_we, waddr=ld_addr, din=ld_din.

REQ-008 In any state other than IDLE, SHALL drive sram_we=0; ld_we is ignored and never queued.

REQ-009 In IDLE with start=1 and ld_we=0, SHALL clear result and ovf and go to HEAD on the next edge.

REQ-010 In IDLE with start=1 and ld_we=1, SHALL perform the write and ignore start; the host must reissue start.

REQ-011 In HEAD, SHALL drive first=1 and sel=1 for exactly one cycle, loading word 0 (the list length N) into the address register, then go to ACC.

REQ-012 In ACC with zero=0:
- drive first=0, sel=0, addr_minus_en=1;
- set result <= result + dout[31:0];
- stay in ACC.

REQ-013 In ACC with zero=1, SHALL not accumulate, SHALL drive addr_minus_en=0, and SHALL go to DONE.

REQ-014 Result content: result SHALL equal the sum of words N, N-1, ..., 1; word 0 is never added.

REQ-015 Empty list: N=0 SHALL yield result=0.

REQ-016 Latency: with start accepted at edge T, done SHALL be high in cycle T+3+N.
- N is the low 9 bits of word 0.
- The maximum N of 511 gives 514 cycles.

REQ-017 Arithmetic: addition SHALL be modulo 2^32; a carry out of bit 31 on any add SHALL set ovf, which stays set until the next accepted start.

REQ-018 In DONE, SHALL assert done for one cycle, drive datapath controls to 0, and return to IDLE.

REQ-019 Abort:
- abort=1 in any state SHALL force IDLE on the next edge.
- No done pulse is issued.
- result keeps its partial value.

REQ-020 abort SHALL have priority over start.

REQ-021 start asserted while busy=1 SHALL be ignored.

Reset
REQ-022 When rst=1 at a clock edge, SHALL set:
- state=IDLE;
- result=0, ovf=0, done=0, busy=0;
- first=0, sel=0, addr_minus_en=0, sram_we=0.

REQ-023 rst SHALL take priority over abort, start and ld_we; a reset mid-traversal discards the traversal with no done pulse.

Configuration
REQ-024 The macro SRAM_ADD_CTRL_OVF_EN SHALL control overflow detection:
- defined: ovf behaves as in REQ-017;
- undefined: ovf is tied to 0 and no carry logic is built; all other behaviour is identical.

Verification
REQ-025 Basic sum:
- Stimulus: load mem[0]=3, mem[1]=10, mem[2]=20, mem[3]=30; pulse start at T.
- Response: done at T+6, result=60, busy high T+1..T+6.

REQ-026 Empty list:
- Stimulus: mem[0]=0; start at T.
- Response: done at T+3, result=0, the datapath address register is never decremented.

REQ-027 Overflow (macro defined):
- Stimulus: mem[0]=2, mem[1]=0xFFFF_FFFF, mem[2]=0x0000_0002.
- Response: result=0x0000_0001, ovf=1.
- Same stimulus with the macro undefined: ovf=0.

REQ-028 Load lockout:
- Stimulus: ld_we=1 with ld_addr=5 during ACC.
- Response: sram_we stays 0 and mem[5] is unchanged.
- Stimulus: ld_we=1 together with start in IDLE.
- Response: the write occurs and the block stays in IDLE.

REQ-029 Abort and reset mid-run:
- Stimulus: abort in cycle T+3 of an N=5 run.
- Response: IDLE at T+4, no done, busy=0.
- Stimulus: rst in ACC.
- Response: all outputs at their reset values on the next cycle.

REQ-030 Back-to-back runs:
- Stimulus: second start in the cycle after done.
- Response: result cleared, second run completes with its own correct sum, and no stale ovf.
